assoc_cache_memory: RTL

Parametrised N-way set-associative, write-back, write-allocate data cache between the CPU load/store path and the block-wide data memory. It generalises the direct-mapped lab cache in address width, word width, block size, set count and associativity, and adds per-set LRU replacement. The CPU-side handshake is unchanged: CPU holds a request while BUSYWAIT is high.

---
 rtl/assoc_cache_memory.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/assoc_cache_memory.sv
// N-way set-associative write-back, write-allocate data cache with per-set LRU ages.
// The CPU holds its request while busywait_o is high; memory moves whole blocks.
//
// state        | meaning
// S_IDLE       | serve hits; on a miss latch tag/index/victim and pick next state
// S_WRITE_BACK | dirty victim block driven to memory until mem_busywait_i drops
// S_FETCH      | missing block requested from memory, captured when mem_busywait_i drops
// S_UPDATE     | fetched block installed in the victim way (clean, valid)
module assoc_cache_memory #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int WORDS  = 4,
   parameter int SETS   = 4,
   parameter int WAYS   = 2
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic                             read_i,
   input  logic                             write_i,
   input  logic [ADDR_W-1:0]                address_i,
   input  logic [DATA_W-1:0]                writedata_i,
   output logic [DATA_W-1:0]                readdata_o,
   output logic                             busywait_o,
   output logic                             mem_read_o,
   output logic                             mem_write_o,
   output logic [ADDR_W-$clog2(WORDS)-1:0]  mem_address_o,
   output logic [DATA_W*WORDS-1:0]          mem_writedata_o,
   input  logic [DATA_W*WORDS-1:0]          mem_readdata_i,
   input  logic                             mem_busywait_i
);

   localparam int OFF_W  = $clog2(WORDS);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int BLK_W  = ADDR_W - OFF_W;
   localparam int LINE_W = DATA_W * WORDS;
   localparam int IDX_WL = (IDX_W > 0) ? IDX_W : 1;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WRITE_BACK, S_FETCH, S_UPDATE} state_t;

   state_t              state_q;
   logic                valid_q [SETS][WAYS];
   logic                dirty_q [SETS][WAYS];
   logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
   logic [LINE_W-1:0]   data_q  [SETS][WAYS];
   logic [WAY_W-1:0]    age_q   [SETS][WAYS];

   logic [IDX_WL-1:0]   lat_idx_q;
   logic [TAG_W-1:0]    lat_tag_q;
   logic [WAY_W-1:0]    victim_q;
   logic [LINE_W-1:0]   fill_q;
   logic                mem_read_q;
   logic                mem_write_q;
   logic [BLK_W-1:0]    mem_addr_q;
   logic [LINE_W-1:0]   mem_wdata_q;

   logic [BLK_W-1:0]    req_blk;
   logic [OFF_W-1:0]    req_off;
   logic [IDX_WL-1:0]   req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic                req;

   logic                hit;
   logic [WAY_W-1:0]    hit_way;
   logic                inv_found;
   logic [WAY_W-1:0]    inv_way;
   logic [WAY_W-1:0]    old_way;
   logic [WAY_W-1:0]    max_age;
   logic [WAY_W-1:0]    victim_way;
   logic [LINE_W-1:0]   hit_line;

   function automatic logic [BLK_W-1:0] blk_addr(input logic [TAG_W-1:0] t,
                                                 input logic [IDX_WL-1:0] i);
      logic [BLK_W-1:0] idx_part;
      idx_part = (IDX_W == 0) ? '0 : BLK_W'(i);
      return (BLK_W'(t) << IDX_W) | idx_part;
   endfunction

   assign req_blk = address_i[ADDR_W-1:OFF_W];
   assign req_off = address_i[OFF_W-1:0];
   assign req_idx = (IDX_W == 0) ? '0 : IDX_WL'(req_blk);
   assign req_tag = TAG_W'(req_blk >> IDX_W);
   assign req     = read_i | write_i;

   // Ages within a set are a permutation, so the max-age way is unique.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      old_way   = '0;
      max_age   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag) && !hit) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[req_idx][w] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
         if (age_q[req_idx][w] >= max_age) begin
            max_age = age_q[req_idx][w];
            old_way = WAY_W'(w);
         end
      end
      victim_way = inv_found ? inv_way : old_way;
   end

   assign hit_line        = data_q[req_idx][hit_way];
   assign readdata_o      = (state_q == S_IDLE && req && hit) ? hit_line[req_off*DATA_W +: DATA_W] : '0;
   assign busywait_o      = (state_q != S_IDLE) || (req && !hit);
   assign mem_read_o      = mem_read_q;
   assign mem_write_o     = mem_write_q;
   assign mem_address_o   = mem_addr_q;
   assign mem_writedata_o = mem_wdata_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         lat_idx_q   <= '0;
         lat_tag_q   <= '0;
         victim_q    <= '0;
         fill_q      <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               dirty_q[s][w] <= 1'b0;
               tag_q[s][w]   <= '0;
               data_q[s][w]  <= '0;
               age_q[s][w]   <= WAY_W'(w);
            end
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req && hit) begin
                  if (write_i) begin
                     data_q[req_idx][hit_way][req_off*DATA_W +: DATA_W] <= writedata_i;
                     dirty_q[req_idx][hit_way] <= 1'b1;
                  end
                  if (WAYS > 1) begin
                     for (int w = 0; w < WAYS; w++) begin
                        if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                           age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
                     end
                     age_q[req_idx][hit_way] <= '0;
                  end
               end else if (req) begin
                  lat_idx_q <= req_idx;
                  lat_tag_q <= req_tag;
                  victim_q  <= victim_way;
                  if (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way]) begin
                     state_q     <= S_WRITE_BACK;
                     mem_write_q <= 1'b1;
                     mem_addr_q  <= blk_addr(tag_q[req_idx][victim_way], req_idx);
                     mem_wdata_q <= data_q[req_idx][victim_way];
                  end else begin
                     state_q    <= S_FETCH;
                     mem_read_q <= 1'b1;
                     mem_addr_q <= blk_addr(req_tag, req_idx);
                  end
               end
            end
            S_WRITE_BACK: begin
               if (!mem_busywait_i) begin
                  state_q     <= S_FETCH;
                  mem_write_q <= 1'b0;
                  mem_read_q  <= 1'b1;
                  mem_addr_q  <= blk_addr(lat_tag_q, lat_idx_q);
                  mem_wdata_q <= '0;
               end
            end
            S_FETCH: begin
               if (!mem_busywait_i) begin
                  state_q    <= S_UPDATE;
                  fill_q     <= mem_readdata_i;
                  mem_read_q <= 1'b0;
                  mem_addr_q <= '0;
               end
            end
            S_UPDATE: begin
               data_q[lat_idx_q][victim_q]  <= fill_q;
               valid_q[lat_idx_q][victim_q] <= 1'b1;
               dirty_q[lat_idx_q][victim_q] <= 1'b0;
               tag_q[lat_idx_q][victim_q]   <= lat_tag_q;
               state_q                      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
